mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Clocked two-requester arbiter. It shares one line-wide backing memory controller (UART memory link) between port 1 (instruction fetch, read-only) and port 2 (data: read or write).
- Registers every request, issues one single-cycle command to the memory controller, waits for completion, latches read data and returns a one-cycle done pulse to the winner.
- Sits between the L1 caches and the memory/UART controller.

Parameters:
- ADDR_W, 32, byte-address width (matches `ADDR_WIDTH` in config.vh)
- LINE_W, 256, cache-line data width
- STARVE_MAX, 4, consecutive port-2 grants allowed while port 1 waits before port 1 is forced

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- read_op1  in  1  port-1 read request (level)
- addr1  in  ADDR_W  port-1 line address
- data1_o  out  LINE_W  port-1 read data, valid when done1=1
- busy1  out  1  port-1 transaction accepted and in flight
- done1  out  1  port-1 completion pulse
- read_op2  in  1  port-2 read request (level)
- write_op  in  1  port-2 write request (level)
- addr2  in  ADDR_W  port-2 line address
- data2_i  in  LINE_W  port-2 write data
- data2_o  out  LINE_W  port-2 read data, valid when done2=1
- busy2  out  1  port-2 in flight
- done2  out  1  port-2 completion pulse
- mem_read  out  1  command pulse to memory controller: read
- mem_write  out  1  command pulse: write
- mem_addr  out  ADDR_W  command address, held from ISSUE until completion
- mem_data_o  out  LINE_W  write data, held from ISSUE until completion
- mem_data_i  in  LINE_W  read data, valid with mem_done
- mem_busy  in  1  memory controller busy
- mem_done  in  1  memory controller completion pulse

Behaviour:
- Reset values: state=IDLE; all outputs 0 (data1_o, data2_o, mem_addr, mem_data_o included); starve counter 0.
- Reset mid-transaction: same values next cycle. A later stray mem_done in IDLE is ignored.
- All outputs are registered.
- FSM states are IDLE, ISSUE, WAIT, DONE.
- IDLE: sample the requests.
  - Port 2 (read_op2 or write_op) has priority over read_op1.
  - Exception: if starve_cnt == STARVE_MAX and read_op1=1, port 1 wins.
  - On a grant: latch owner, op, addr, and data2_i (writes only); set the owner's busy; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: only if mem_busy=0, drive mem_read or mem_write =1 for exactly one cycle, then go to WAIT. If mem_busy=1, hold in ISSUE with the command at 0.
- WAIT: on mem_done=1:
  - For a read, latch mem_data_i into the owner's data register (data1_o or data2_o).
  - Clear busy, set done, go to DONE.
  - mem_done in the same cycle as the command pulse is not legal; it is ignored.
- DONE: done is high for exactly this one cycle; return to IDLE. The requester drops its op at the edge where it samples done=1, so IDLE never re-issues the same request.
- Latency: request seen in IDLE at cycle N; command pulse at N+1 (if mem_busy=0); done at M+1, where M is the mem_done cycle.
- Starve counter:
  - +1 on each port-2 grant while read_op1=1; saturates at STARVE_MAX.
  - Clears to 0 on a port-1 grant.
  - Holds when read_op1=0.
- read_op2 and write_op both high: the read is served and the write is ignored (protocol violation, flagged by a simulation assertion).
- Requests are sampled only in IDLE. A request dropped mid-flight does not abort the transaction; done still pulses.
- data1_o and data2_o hold their value until the next read completion for that port.

Decomposition:
- Shared header (config.vh): ADDR_WIDTH, LINE_WIDTH, state encodings (IDLE/ISSUE/WAIT/DONE as 2-bit localparams), owner encoding (OWN_P1, OWN_P2).
- Single module, no sub-module: the FSM and starve counter stay inline.

Test Plan:
- Port-1 read only: read_op1=1, addr1=0x100, mem_done 5 cycles after the pulse with mem_data_i=0xA5…A5 -> one-cycle mem_read with mem_addr=0x100; busy1 high through WAIT; done1 for one cycle with data1_o=0xA5…A5.
- Simultaneous requests: read_op1=1 and write_op=1 (addr2=0x40, data2_i=0x1234) in one cycle -> port 2 served first (mem_write, mem_data_o=0x1234), then port 1 read; done2 precedes done1.
- Starvation: read_op1 held while port 2 requests back-to-back, STARVE_MAX=4 -> after the 4th port-2 grant the next grant goes to port 1 and the counter returns to 0.
- Backpressure: mem_busy=1 for 3 cycles at ISSUE -> no command pulse during those cycles; exactly one mem_read when mem_busy falls.
- Reset in WAIT: RST for 1 cycle, then a stray mem_done -> all outputs 0, no done pulse, FSM stays in IDLE.
- read_op2 and write_op both high -> mem_read issued, no mem_write; assertion fires.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, FSM state and owner encodings
// for the two-port line memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int LINE_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_P1 = 1'b0,
    OWN_P2 = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch / data) in front of one
// line-wide memory controller; fully registered outputs.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_WIDTH,
  parameter int LINE_W     = LINE_WIDTH,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              read_op1,
  input  logic [ADDR_W-1:0] addr1,
  output logic [LINE_W-1:0] data1_o,
  output logic              busy1,
  output logic              done1,
  input  logic              read_op2,
  input  logic              write_op,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [LINE_W-1:0] data2_i,
  output logic [LINE_W-1:0] data2_o,
  output logic              busy2,
  output logic              done2,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_busy,
  input  logic              mem_done
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  state_t          state_q, state_d;
  owner_t          own_q, own_d;
  logic            wr_q, wr_d;
  logic [SW-1:0]   starve_q, starve_d;

  logic [LINE_W-1:0] data1_d, data2_d, mdata_d;
  logic [ADDR_W-1:0] maddr_d;
  logic busy1_d, busy2_d, done1_d, done2_d;
  logic mrd_d, mwr_d;

  logic p2_req, force_p1, grant2, grant1;
  logic p2_wr;

  assign p2_req   = read_op2 | write_op;
  assign force_p1 = read_op1 && (starve_q == SMAX);
  assign grant2   = p2_req && !force_p1;
  assign grant1   = read_op1 && !grant2;
  // a read wins when both port-2 ops are raised
  assign p2_wr    = write_op && !read_op2;

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    wr_d     = wr_q;
    starve_d = starve_q;
    data1_d  = data1_o;
    data2_d  = data2_o;
    mdata_d  = mem_data_o;
    maddr_d  = mem_addr;
    busy1_d  = busy1;
    busy2_d  = busy2;
    done1_d  = 1'b0;
    done2_d  = 1'b0;
    mrd_d    = 1'b0;
    mwr_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant2) begin
          own_d   = OWN_P2;
          wr_d    = p2_wr;
          maddr_d = addr2;
          if (p2_wr) mdata_d = data2_i;
          busy2_d = 1'b1;
          state_d = ISSUE;
          if (read_op1 && starve_q != SMAX)
            starve_d = starve_q + 1'b1;
        end else if (grant1) begin
          own_d    = OWN_P1;
          wr_d     = 1'b0;
          maddr_d  = addr1;
          busy1_d  = 1'b1;
          starve_d = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (!mem_busy) begin
          mrd_d   = !wr_q;
          mwr_d   = wr_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // completion alongside the command pulse is not legal
        if (mem_done && !(mem_read || mem_write)) begin
          if (own_q == OWN_P1) begin
            if (!wr_q) data1_d = mem_data_i;
            busy1_d = 1'b0;
            done1_d = 1'b1;
          end else begin
            if (!wr_q) data2_d = mem_data_i;
            busy2_d = 1'b0;
            done2_d = 1'b1;
          end
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      own_q      <= OWN_P1;
      wr_q       <= 1'b0;
      starve_q   <= '0;
      data1_o    <= '0;
      data2_o    <= '0;
      mem_data_o <= '0;
      mem_addr   <= '0;
      busy1      <= 1'b0;
      busy2      <= 1'b0;
      done1      <= 1'b0;
      done2      <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      wr_q       <= wr_d;
      starve_q   <= starve_d;
      data1_o    <= data1_d;
      data2_o    <= data2_d;
      mem_data_o <= mdata_d;
      mem_addr   <= maddr_d;
      busy1      <= busy1_d;
      busy2      <= busy2_d;
      done1      <= done1_d;
      done2      <= done2_d;
      mem_read   <= mrd_d;
      mem_write  <= mwr_d;
    end
  end

  always @(posedge CLK) begin
    if (!RST && state_q == IDLE)
      assert (!(read_op2 && write_op))
        else $warning("mem_arbiter: read_op2 and write_op both high, write dropped");
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a hand-driven
// memory controller and fixed expected values.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  typedef logic [LW-1:0] w_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          read_op1, read_op2, write_op;
  logic [AW-1:0] addr1, addr2, mem_addr;
  logic [LW-1:0] data1_o, data2_o, data2_i;
  logic [LW-1:0] mem_data_o, mem_data_i;
  logic          busy1, busy2, done1, done2;
  logic          mem_read, mem_write, mem_busy, mem_done;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_MAX(4)) dut (
    .CLK(CLK), .RST(RST),
    .read_op1(read_op1), .addr1(addr1),
    .data1_o(data1_o), .busy1(busy1), .done1(done1),
    .read_op2(read_op2), .write_op(write_op),
    .addr2(addr2), .data2_i(data2_i),
    .data2_o(data2_o), .busy2(busy2), .done2(done2),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_busy(mem_busy),
    .mem_done(mem_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input w_t got, input w_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // wait for a command, then complete it lat cycles after the pulse
  task automatic serve(input w_t rdata, input int lat,
                       output logic rd, output logic wr,
                       output logic [AW-1:0] a, output w_t wd,
                       output logic [1:0] bz);
    int n = 0;
    while (!(mem_read || mem_write) && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_seen", w_t'(mem_read | mem_write), w_t'(1));
    rd = mem_read;
    wr = mem_write;
    a  = mem_addr;
    wd = mem_data_o;
    tick();
    chk("cmd_one_cycle", w_t'(mem_read | mem_write), w_t'(0));
    bz = {busy2, busy1};
    repeat (lat - 1) tick();
    mem_done   = 1'b1;
    mem_data_i = rdata;
    tick();
    mem_done = 1'b0;
  endtask

  logic          rd, wr;
  logic [AW-1:0] a;
  w_t            wd;
  logic [1:0]    bz;
  w_t            a5;
  logic          p1;

  initial begin
    a5 = {32{8'hA5}};
    RST = 1'b1;
    read_op1 = 0; read_op2 = 0; write_op = 0;
    addr1 = '0; addr2 = '0; data2_i = '0;
    mem_data_i = '0; mem_busy = 0; mem_done = 0;
    tick(); tick();
    chk("rst_busy1", w_t'(busy1), w_t'(0));
    chk("rst_busy2", w_t'(busy2), w_t'(0));
    chk("rst_done1", w_t'(done1), w_t'(0));
    chk("rst_done2", w_t'(done2), w_t'(0));
    chk("rst_mrd", w_t'(mem_read), w_t'(0));
    chk("rst_mwr", w_t'(mem_write), w_t'(0));
    chk("rst_maddr", w_t'(mem_addr), w_t'(0));
    chk("rst_mdata", mem_data_o, w_t'(0));
    chk("rst_data1", data1_o, w_t'(0));
    chk("rst_data2", data2_o, w_t'(0));
    RST = 1'b0;

    // port-1 read, completion 5 cycles after the pulse
    read_op1 = 1; addr1 = 32'h100;
    tick();
    chk("p1_busy", w_t'(busy1), w_t'(1));
    chk("p1_no_cmd_yet", w_t'(mem_read), w_t'(0));
    serve(a5, 5, rd, wr, a, wd, bz);
    chk("p1_rd", w_t'(rd), w_t'(1));
    chk("p1_wr", w_t'(wr), w_t'(0));
    chk("p1_addr", w_t'(a), w_t'(32'h100));
    chk("p1_busy_wait", w_t'(bz), w_t'(2'b01));
    chk("p1_done1", w_t'(done1), w_t'(1));
    chk("p1_done2", w_t'(done2), w_t'(0));
    chk("p1_busy_clr", w_t'(busy1), w_t'(0));
    chk("p1_data", data1_o, a5);
    read_op1 = 0;
    tick();
    chk("p1_done_pulse", w_t'(done1), w_t'(0));
    chk("p1_data_hold", data1_o, a5);

    // simultaneous: port-2 write first, then port-1 read
    read_op1 = 1; addr1 = 32'h200;
    write_op = 1; addr2 = 32'h40; data2_i = w_t'(16'h1234);
    tick();
    chk("sim_busy2", w_t'(busy2), w_t'(1));
    chk("sim_busy1", w_t'(busy1), w_t'(0));
    serve(w_t'(0), 2, rd, wr, a, wd, bz);
    chk("sim_wr", w_t'(wr), w_t'(1));
    chk("sim_rd", w_t'(rd), w_t'(0));
    chk("sim_waddr", w_t'(a), w_t'(32'h40));
    chk("sim_wdata", wd, w_t'(16'h1234));
    chk("sim_done2", w_t'(done2), w_t'(1));
    chk("sim_done1_early", w_t'(done1), w_t'(0));
    write_op = 0;
    tick();
    chk("sim_done2_pulse", w_t'(done2), w_t'(0));
    serve(w_t'(32'hBEEF), 3, rd, wr, a, wd, bz);
    chk("sim_p1_rd", w_t'(rd), w_t'(1));
    chk("sim_p1_addr", w_t'(a), w_t'(32'h200));
    chk("sim_done1", w_t'(done1), w_t'(1));
    chk("sim_data1", data1_o, w_t'(32'hBEEF));
    chk("sim_data2_write", data2_o, w_t'(0));
    read_op1 = 0;
    tick();

    // starvation: 4 port-2 grants, then port 1, then port 2
    read_op1 = 1; addr1 = 32'h300;
    read_op2 = 1; addr2 = 32'h80;
    for (int k = 0; k < 6; k++) begin
      serve(w_t'(k + 16), 2, rd, wr, a, wd, bz);
      p1 = (k == 4);
      chk("stv_done1", w_t'(done1), w_t'(p1));
      chk("stv_done2", w_t'(done2), w_t'(!p1));
      chk("stv_addr", w_t'(a), p1 ? w_t'(32'h300) : w_t'(32'h80));
      if (p1) begin
        chk("stv_data1", data1_o, w_t'(k + 16));
        read_op1 = 0;
      end else begin
        chk("stv_data2", data2_o, w_t'(k + 16));
      end
    end
    read_op2 = 0;
    tick();

    // backpressure, plus an illegal same-cycle mem_done
    mem_busy = 1;
    read_op1 = 1; addr1 = 32'h400;
    tick();
    chk("bp_hold0", w_t'(mem_read), w_t'(0));
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("bp_hold", w_t'(mem_read), w_t'(0));
    end
    mem_busy = 0;
    tick();
    chk("bp_pulse", w_t'(mem_read), w_t'(1));
    chk("bp_addr", w_t'(mem_addr), w_t'(32'h400));
    mem_done = 1; mem_data_i = w_t'(8'hEE);
    tick();
    mem_done = 0;
    chk("bp_one_pulse", w_t'(mem_read), w_t'(0));
    chk("bp_early_done", w_t'(done1), w_t'(0));
    chk("bp_still_busy", w_t'(busy1), w_t'(1));
    tick();
    mem_done = 1; mem_data_i = w_t'(77);
    tick();
    mem_done = 0;
    chk("bp_done1", w_t'(done1), w_t'(1));
    chk("bp_data1", data1_o, w_t'(77));
    read_op1 = 0;
    tick();

    // reset while waiting, then a stray completion
    read_op1 = 1; addr1 = 32'h500;
    tick(); tick(); tick();
    chk("rw_in_wait", w_t'(busy1), w_t'(1));
    RST = 1; read_op1 = 0;
    tick();
    RST = 0;
    chk("rw_busy1", w_t'(busy1), w_t'(0));
    chk("rw_maddr", w_t'(mem_addr), w_t'(0));
    chk("rw_data1", data1_o, w_t'(0));
    chk("rw_mrd", w_t'(mem_read), w_t'(0));
    mem_done = 1; mem_data_i = {LW{1'b1}};
    tick();
    mem_done = 0;
    chk("rw_stray_done1", w_t'(done1), w_t'(0));
    chk("rw_stray_done2", w_t'(done2), w_t'(0));
    tick();
    chk("rw_idle_mrd", w_t'(mem_read), w_t'(0));
    chk("rw_idle_data1", data1_o, w_t'(0));

    // both port-2 ops: read served, write dropped
    read_op2 = 1; write_op = 1;
    addr2 = 32'h600; data2_i = w_t'(16'hDEAD);
    tick();
    chk("both_busy2", w_t'(busy2), w_t'(1));
    serve(w_t'(16'hCAFE), 2, rd, wr, a, wd, bz);
    chk("both_rd", w_t'(rd), w_t'(1));
    chk("both_wr", w_t'(wr), w_t'(0));
    chk("both_wdata", wd, w_t'(0));
    chk("both_done2", w_t'(done2), w_t'(1));
    chk("both_data2", data2_o, w_t'(16'hCAFE));
    read_op2 = 0; write_op = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
